add_subs: RTL and testbench



---
 rtl/add_subs_if.sv | 34 +++
 rtl/add_subs.sv | 66 ++++++
 tb/tb_add_subs.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/add_subs_if.sv
// Operand/result bundle for the registered adder/subtractor.
// ovf exists only when ADD_SUBS_OVF_EN is defined.
interface add_subs_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             m;
  logic             enable;
  logic [WIDTH:0]   sum;
`ifdef ADD_SUBS_OVF_EN
  logic             ovf;

  modport master (
    output a, b, m, enable,
    input  sum, ovf
  );

  modport slave (
    input  a, b, m, enable,
    output sum, ovf
  );
`else
  modport master (
    output a, b, m, enable,
    input  sum
  );

  modport slave (
    input  a, b, m, enable,
    output sum
  );
`endif
endinterface

// File: rtl/add_subs.sv
// Registered WIDTH-bit ripple-carry adder/subtractor (m=1: a + ~b + 1).
// Optional signed-overflow output enabled by ADD_SUBS_OVF_EN.
module add_subs #(
  parameter int unsigned WIDTH = 4
) (
  input logic       clk,
  input logic       rst_n,
  add_subs_if.slave bus
);

  logic [WIDTH-1:0] s;
  logic             cout;
  logic [WIDTH:0]   sum_q;
`ifdef ADD_SUBS_OVF_EN
  logic             cin_msb;
  logic             ovf_q;
`endif

  always_comb begin : ripple
    logic carry;
    logic bx;
    s     = '0;
    carry = bus.m;
    bx    = 1'b0;
`ifdef ADD_SUBS_OVF_EN
    cin_msb = 1'b0;
`endif
    for (int unsigned i = 0; i < WIDTH; i++) begin
      bx = bus.b[i] ^ bus.m;
`ifdef ADD_SUBS_OVF_EN
      if (i == WIDTH - 1) cin_msb = carry;
`endif
      s[i]  = bus.a[i] ^ bx ^ carry;
      carry = (bus.a[i] & bx) | (carry & (bus.a[i] ^ bx));
    end
    // Carry-out is not inverted in subtract mode: 1 means no borrow.
    cout = carry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (bus.enable) begin
      sum_q <= {cout, s};
    end else begin
      sum_q <= '0;
    end
  end

  assign bus.sum = sum_q;

`ifdef ADD_SUBS_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (bus.enable) begin
      ovf_q <= cin_msb ^ cout;
    end else begin
      ovf_q <= 1'b0;
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_add_subs.sv
// Self-checking bench for add_subs: integer reference model compared every cycle,
// plus directed literal checks; honours ADD_SUBS_OVF_EN.
module tb_add_subs;

  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [W:0] exp_sum;
  logic       exp_ovf;

  add_subs_if #(.WIDTH(W)) bus ();

  add_subs #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                                output logic [W:0] s, output logic o);
    int ua, ub, sa, sb, r, sr;
    logic c;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 2 ** (W - 1)) ? ua - 2 ** W : ua;
    sb = (ub >= 2 ** (W - 1)) ? ub - 2 ** W : ub;
    if (m) begin
      r  = (ua - ub + 2 ** W) % (2 ** W);
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = (ua + ub) % (2 ** W);
      c  = (ua + ub >= 2 ** W);
      sr = sa + sb;
    end
    s = {c, r[W-1:0]};
    o = (sr > 2 ** (W - 1) - 1) || (sr < -(2 ** (W - 1)));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_sum = '0;
      exp_ovf = 1'b0;
    end else if (bus.enable) begin
      model(bus.a, bus.b, bus.m, exp_sum, exp_ovf);
    end else begin
      exp_sum = '0;
      exp_ovf = 1'b0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    checks++;
    if (bus.sum !== exp_sum) begin
      errors++;
      $display("FAIL model_sum t=%0t: got %b expected %b", $time, bus.sum, exp_sum);
    end
`ifdef ADD_SUBS_OVF_EN
    checks++;
    if (bus.ovf !== exp_ovf) begin
      errors++;
      $display("FAIL model_ovf t=%0t: got %b expected %b", $time, bus.ovf, exp_ovf);
    end
`endif
  end

  task automatic check_lit(input string name, input logic [W:0] want_sum, input logic want_ovf);
    checks++;
    if (bus.sum !== want_sum) begin
      errors++;
      $display("FAIL %s: sum got %b expected %b", name, bus.sum, want_sum);
    end
`ifdef ADD_SUBS_OVF_EN
    checks++;
    if (bus.ovf !== want_ovf) begin
      errors++;
      $display("FAIL %s: ovf got %b expected %b", name, bus.ovf, want_ovf);
    end
`else
    if (want_ovf === 1'bx) $display("unused ovf expectation");
`endif
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                       input logic en);
    bus.a      = a;
    bus.b      = b;
    bus.m      = m;
    bus.enable = en;
  endtask

  task automatic step_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic m, input logic en, input logic [W:0] want_sum,
                            input logic want_ovf);
    @(negedge clk);
    drive(a, b, m, en);
    @(posedge clk);
    #1;
    check_lit(name, want_sum, want_ovf);
  endtask

  initial begin
    rst_n = 1'b1;
    drive(4'b0111, 4'b0001, 1'b0, 1'b1);
    #1 rst_n = 1'b0;
    #1 check_lit("reset_immediate", 5'b00000, 1'b0);
    repeat (2) @(posedge clk);
    #1 check_lit("reset_held", 5'b00000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    step_check("add_8_8",        4'b1000, 4'b1000, 1'b1 ^ 1'b1, 1'b1, 5'b10000, 1'b1);
    step_check("sub_3_0",        4'b0011, 4'b0000, 1'b1, 1'b1, 5'b10011, 1'b0);
    step_check("sub_5_0",        4'b0101, 4'b0000, 1'b1, 1'b1, 5'b10101, 1'b0);
    step_check("sub_2_5_borrow", 4'b0010, 4'b0101, 1'b1, 1'b1, 5'b01101, 1'b0);
    step_check("sub_8_8",        4'b1000, 4'b1000, 1'b1, 1'b1, 5'b10000, 1'b0);
    step_check("add_6_0",        4'b0110, 4'b0000, 1'b0, 1'b1, 5'b00110, 1'b0);
    step_check("enable_low",     4'b0110, 4'b0000, 1'b0, 1'b0, 5'b00000, 1'b0);
    step_check("add_6_0_again",  4'b0110, 4'b0000, 1'b0, 1'b1, 5'b00110, 1'b0);
    step_check("add_7_1_ovf",    4'b0111, 4'b0001, 1'b0, 1'b1, 5'b01000, 1'b1);

    // Async reset between edges must clear without a clock.
    @(negedge clk);
    drive(4'b0110, 4'b0000, 1'b0, 1'b1);
    @(posedge clk);
    #1 check_lit("pre_async_reset", 5'b00110, 1'b0);
    #1 rst_n = 1'b0;
    #1 check_lit("async_reset", 5'b00000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step_check("after_reset_add", 4'b0001, 4'b0001, 1'b0, 1'b1, 5'b00010, 1'b0);

    // Randomized phase with occasional mid-cycle reset pulses.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      drive(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0));
      if ($urandom_range(0, 39) == 0) begin
        #1 rst_n = 1'b0;
        #1 check_lit("rand_async_reset", 5'b00000, 1'b0);
        rst_n = 1'b1;
      end
    end
    @(negedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
